// File: rtl/stall_control.sv
// Pipeline stall generator: one-cycle load stall, two-cycle jump stall, halt freeze.
// Optional STALL_CONTROL_HALT_LATCH_EN makes a halt sticky until reset.
module stall_control #(
  parameter logic [5:0] OP_LD  = 6'b010100,
  parameter logic [5:0] OP_JMP = 6'b011110,
  parameter logic [5:0] OP_HLT = 6'b010001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       stall,
  output logic       stall_pm
);

  logic       ld_q;
  logic [1:0] jc_q;
  logic       halt_q;

  logic is_ld;
  logic is_jmp;
  logic is_hlt;
  logic ld_stall;
  logic jmp_stall;
  logic hlt_stall;

  assign is_ld  = (op == OP_LD);
  assign is_jmp = (op == OP_JMP);
  assign is_hlt = (op == OP_HLT);

  always_comb begin
    ld_stall  = is_ld & ~ld_q;
    jmp_stall = is_jmp & (jc_q != 2'd2);
    hlt_stall = is_hlt | halt_q;
    stall     = ld_stall | jmp_stall | hlt_stall;
  end

  // Any non-stalling cycle drops the counters, so a changed opcode restarts cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_q     <= 1'b0;
      jc_q     <= 2'd0;
      stall_pm <= 1'b0;
    end else begin
      ld_q     <= ld_stall;
      jc_q     <= jmp_stall ? jc_q + 2'd1 : 2'd0;
      stall_pm <= stall;
    end
  end

`ifdef STALL_CONTROL_HALT_LATCH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_q <= 1'b0;
    end else if (is_hlt) begin
      halt_q <= 1'b1;
    end
  end
`else
  assign halt_q = 1'b0;
`endif

endmodule

// File: tb/tb_stall_control.sv
// Directed self-checking bench for stall_control; halt checks follow
// STALL_CONTROL_HALT_LATCH_EN as the DUT does.
module tb_stall_control;

  localparam logic [5:0] OP_LD  = 6'b010100;
  localparam logic [5:0] OP_JMP = 6'b011110;
  localparam logic [5:0] OP_HLT = 6'b010001;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       stall;
  logic       stall_pm;

  int tests = 0;
  int failures = 0;

  stall_control #(
    .OP_LD (OP_LD),
    .OP_JMP(OP_JMP),
    .OP_HLT(OP_HLT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .op      (op),
    .stall   (stall),
    .stall_pm(stall_pm)
  );

  always #5 clk = ~clk;

  // Leaves the bench just after a rising edge with reset released and state cleared.
  task automatic do_reset();
    reset = 1'b1;
    op    = 6'h00;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    op    = 6'h00;
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_stall: got %b want 0", stall);
    end
    tests++;
    if (stall_pm !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_stall_pm: got %b want 0", stall_pm);
    end
    @(posedge clk);
    #1;
    op = OP_LD;
    #1;
    tests++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL reset_decode_ld: got %b want 1", stall);
    end
    @(posedge clk);
    #1;
    tests++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL reset_held_ld_q_clear: got %b want 1", stall);
    end
    tests++;
    if (stall_pm !== 1'b0) begin
      failures++;
      $display("FAIL reset_held_stall_pm: got %b want 0", stall_pm);
    end
    op = 6'h00;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_load();
    logic [5:0] ops [3] = '{OP_LD, OP_LD, 6'h00};
    logic       es  [3] = '{1'b1, 1'b0, 1'b0};
    logic       ep  [3] = '{1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      op = ops[i];
      @(negedge clk);
      tests++;
      if (stall !== es[i]) begin
        failures++;
        $display("FAIL load_stall cyc %0d: got %b want %b", i, stall, es[i]);
      end
      tests++;
      if (stall_pm !== ep[i]) begin
        failures++;
        $display("FAIL load_stall_pm cyc %0d: got %b want %b", i, stall_pm, ep[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_jump();
    logic [5:0] ops [4] = '{OP_JMP, OP_JMP, OP_JMP, 6'h00};
    logic       es  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       ep  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      op = ops[i];
      @(negedge clk);
      tests++;
      if (stall !== es[i]) begin
        failures++;
        $display("FAIL jump_stall cyc %0d: got %b want %b", i, stall, es[i]);
      end
      tests++;
      if (stall_pm !== ep[i]) begin
        failures++;
        $display("FAIL jump_stall_pm cyc %0d: got %b want %b", i, stall_pm, ep[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_held_jump();
    logic es [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    op = OP_JMP;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if (stall !== es[i]) begin
        failures++;
        $display("FAIL held_jump_stall cyc %0d: got %b want %b", i, stall, es[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Other opcodes never stall and clear a pending load/jump sequence.
  task automatic test_other_ops();
    logic [5:0] others [5] = '{6'h00, 6'h3f, 6'h15, 6'h1f, 6'h10};
    logic [5:0] ops    [3] = '{OP_LD, 6'h3f, OP_LD};
    logic       es     [3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      op = others[i];
      @(negedge clk);
      tests++;
      if (stall !== 1'b0) begin
        failures++;
        $display("FAIL other_op %h stall: got %b want 0", others[i], stall);
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) begin
      op = ops[i];
      @(negedge clk);
      tests++;
      if (stall !== es[i]) begin
        failures++;
        $display("FAIL other_clears_ld cyc %0d: got %b want %b", i, stall, es[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mid_change();
    logic [5:0] ops [5] = '{OP_JMP, OP_LD, OP_JMP, OP_JMP, OP_JMP};
    logic       es  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      op = ops[i];
      @(negedge clk);
      tests++;
      if (stall !== es[i]) begin
        failures++;
        $display("FAIL mid_change_stall cyc %0d: got %b want %b", i, stall, es[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_halt();
`ifdef STALL_CONTROL_HALT_LATCH_EN
    logic [5:0] ops [4] = '{OP_HLT, 6'h00, OP_LD, OP_JMP};
    logic       es  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic       ep  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
`else
    logic [5:0] ops [4] = '{OP_HLT, 6'h00, 6'h00, OP_HLT};
    logic       es  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       ep  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      op = ops[i];
      @(negedge clk);
      tests++;
      if (stall !== es[i]) begin
        failures++;
        $display("FAIL halt_stall cyc %0d: got %b want %b", i, stall, es[i]);
      end
      tests++;
      if (stall_pm !== ep[i]) begin
        failures++;
        $display("FAIL halt_stall_pm cyc %0d: got %b want %b", i, stall_pm, ep[i]);
      end
      @(posedge clk);
      #1;
    end
    op    = 6'h00;
    reset = 1'b1;
    #1;
    tests++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL halt_after_reset_stall: got %b want 0", stall);
    end
    tests++;
    if (stall_pm !== 1'b0) begin
      failures++;
      $display("FAIL halt_after_reset_stall_pm: got %b want 0", stall_pm);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_jump();
    logic es [3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    op = OP_JMP;
    @(negedge clk);
    tests++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL rst_jump_first: got %b want 1", stall);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    tests++;
    if (stall_pm !== 1'b0) begin
      failures++;
      $display("FAIL rst_jump_async_pm: got %b want 0", stall_pm);
    end
    tests++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL rst_jump_decode: got %b want 1", stall);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (stall !== es[i]) begin
        failures++;
        $display("FAIL rst_jump_restart cyc %0d: got %b want %b", i, stall, es[i]);
      end
      if (i == 0) begin
        tests++;
        if (stall_pm !== 1'b0) begin
          failures++;
          $display("FAIL rst_jump_restart_pm: got %b want 0", stall_pm);
        end
      end
      @(posedge clk);
      #1;
    end
    op = 6'h00;
  endtask

  initial begin
    test_reset();
    test_load();
    test_jump();
    test_held_jump();
    test_other_ops();
    test_mid_change();
    test_halt();
    test_reset_mid_jump();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/stall_control.md
STALL_CONTROL -- requirements
Module: stall_control

Interface
REQ-001 Parameter OP_LD, default 6'b010100: load opcode; requires a one-cycle pipeline stall.
REQ-002 Parameter OP_JMP, default 6'b011110: jump opcode; requires a two-cycle pipeline stall.
REQ-003 Parameter OP_HLT, default 6'b010001: halt opcode; freezes the pipeline.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port op, input, 6 bits: opcode of the instruction in the decode stage.
REQ-007 Port stall, output, 1 bit: combinational stall request to the pipeline registers.
REQ-008 Port stall_pm, output, 1 bit: stall delayed one cycle; freezes program-memory fetch.

Function
REQ-009 The block SHALL hold the following state: ld_q (1 bit), jc (2-bit jump counter), halt_q (1 bit), and stall_pm (1-bit register).
REQ-010 Load stall: ld_stall = (op==OP_LD) & ~ld_q; ld_q <= ld_stall each cycle.
REQ-011 Consequence of REQ-010: OP_LD held for N cycles gives stall=1,0,1,0,...; a single load cycle gives exactly one stall cycle.
REQ-012 Jump stall: jmp_stall = (op==OP_JMP) & (jc!=2); jc <= jmp_stall ? jc+1 : 0.
REQ-013 Consequence of REQ-012: OP_JMP held gives stall=1,1,0, then the pattern repeats; jc never exceeds 2.
REQ-014 Halt stall: hlt_stall = (op==OP_HLT) | halt_q; halt_q behaviour is set by REQ-022/REQ-023.
REQ-015 stall = ld_stall | jmp_stall | hlt_stall; the output is purely combinational from op and the state, with zero latency.
REQ-016 stall_pm <= stall on every rising clk edge, so stall_pm lags stall by exactly one cycle.
REQ-017 Any opcode other than OP_LD, OP_JMP or OP_HLT gives stall=0 (unless halt_q=1) and clears ld_q and jc on the next edge.
REQ-018 A change of op in mid-sequence abandons the old sequence: e.g. JMP then LD after one jump cycle resets jc to 0 and evaluates the load rule immediately.

Reset
REQ-019 While reset=1, ld_q, jc, halt_q and stall_pm SHALL be 0 immediately, without waiting for a clock edge.
REQ-020 During reset, stall follows REQ-015 with all state at 0, so stall equals the op decode only.
REQ-021 Reset asserted mid-sequence (during a jump count or a latched halt) aborts the sequence; after release the block behaves as if freshly started.

Configuration
REQ-022 With macro STALL_CONTROL_HALT_LATCH_EN defined: halt_q is set on the first rising edge where op==OP_HLT and stays set until reset, so stall=1 and stall_pm=1 persist whatever op does.
REQ-023 With STALL_CONTROL_HALT_LATCH_EN undefined: halt_q is tied to 0 and the halt stall lasts only while op==OP_HLT.

Verification
REQ-024 Reset: reset=1, op=0 -> stall=0 and stall_pm=0 asynchronously; the state stays cleared while reset is held.
REQ-025 Load: op=OP_LD for 2 cycles, then 0 -> stall=1,0,0 and stall_pm=0,1,0 (cycle-aligned).
REQ-026 Jump: op=OP_JMP for 3 cycles, then 0 -> stall=1,1,0,0 and stall_pm=0,1,1,0.
REQ-027 Held jump: op=OP_JMP for 6 cycles -> stall=1,1,0,1,1,0.
REQ-028 Halt with STALL_CONTROL_HALT_LATCH_EN: op=OP_HLT for 1 cycle, then 0 -> stall stays 1 and stall_pm is 1 from the next cycle until reset; after reset both are 0.
REQ-029 Halt without the macro, plus reset mid-jump: the halt stall drops when op leaves OP_HLT; reset asserted after the first jump cycle clears jc, and OP_JMP after release stalls again for 2 cycles.
